// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I load/store encodings, LSU FSM states, memory command
// payload and the request-decode helpers used by the load/store unit.
package rv32i_pkg;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  // Command presented on the memory port for the whole access
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_cmd_t;

  // Reserved encodings, and the unsigned variants which exist only for loads
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (is_store && f3[2]);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = lo[0];
      F3_W:        mis = (lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] lanes;
    case (size)
      2'b00:   lanes = {4{wd[7:0]}};
      2'b01:   lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed lane of a read word and sign/zero extends it.
//   mem_rdata : raw 32-bit word from memory
//   addr      : byte offset within the word
//   funct3    : load size/sign
//   result_c  : aligned, extended load value (combinational)
module load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result_c
);

  logic [31:0] shifted;

  // Move the addressed byte/half down to bit 0
  assign shifted = mem_rdata >> {addr, 3'b000};

  always_comb begin
    result_c = shifted;
    case (funct3)
      F3_B:    result_c = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result_c = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result_c = {24'd0, shifted[7:0]};
      F3_HU:   result_c = {16'd0, shifted[15:0]};
      default: result_c = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: executes one RV32I load/store per start strobe over a
// req/ack memory port, with alignment/legality checks and an access timeout.
//   clk, rst            : clock, synchronous active-high reset
//   start, is_store,
//   funct3, addr, wdata : request from execute, sampled with start
//   busy, done, rdata,
//   misaligned, bus_err : status and load result
//   mem_req, mem_we, mem_addr, mem_wdata, mem_be,
//   mem_ack, mem_rdata  : memory port
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t   state_q, state_d;
  mem_cmd_t     cmd_q, cmd_d;
  logic         req_q, req_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic         mis_q, mis_d;
  logic         berr_q, berr_d;
  logic [31:0]  rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]   off_q, off_d;
  logic [2:0]   f3_q, f3_d;
  logic         req_illegal, req_mis;
  logic [31:0]  load_c;

  load_align u_align (
    .mem_rdata (mem_rdata),
    .addr      (off_q),
    .funct3    (f3_q),
    .result_c  (load_c)
  );

  assign req_illegal = f3_illegal(is_store, funct3);
  assign req_mis     = !req_illegal && f3_misaligned(funct3, addr[1:0]);
  assign cnt_inc     = cnt_q + CNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    req_d   = req_q;
    mis_d   = mis_q;
    berr_d  = berr_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    f3_d    = f3_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mis_d  = req_mis;
          berr_d = req_illegal;
          off_d  = addr[1:0];
          f3_d   = funct3;
          if (req_illegal || req_mis) begin
            state_d = ST_RESP;
          end else begin
            state_d     = ST_ACCESS;
            req_d       = 1'b1;
            cnt_d       = '0;
            cmd_d.we    = is_store;
            cmd_d.addr  = {addr[31:2], 2'b00};
            cmd_d.be    = byte_enable(funct3[1:0], addr[1:0]);
            cmd_d.wdata = store_lanes(funct3[1:0], wdata);
          end
        end
      end
      ST_ACCESS: begin
        // An ack in the timeout cycle still completes the access normally
        if (mem_ack) begin
          state_d  = ST_RESP;
          req_d    = 1'b0;
          cmd_d.we = 1'b0;
          if (!cmd_q.we) begin
            rdata_d = load_c;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d  = ST_RESP;
          req_d    = 1'b0;
          cmd_d.we = 1'b0;
          berr_d   = 1'b1;
          cnt_d    = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_RESP);
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      req_q   <= req_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign misaligned = mis_q;
  assign bus_err    = berr_q;
  assign mem_req    = req_q;
  assign mem_we     = cmd_q.we;
  assign mem_addr   = cmd_q.addr;
  assign mem_wdata  = cmd_q.wdata;
  assign mem_be     = cmd_q.be;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit
// against a behavioural model of the access rules (TIMEOUT_CYCLES = 4).
module tb_load_store_unit;

  localparam int unsigned TMO = 4;

  logic        clk, rst, start, is_store, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, misaligned, bus_err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rdata = 32'd0;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misaligned(misaligned), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_legal(input bit st, input int f3);
    if (st) return (f3 == 0 || f3 == 1 || f3 == 2);
    return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
  endfunction

  function automatic int m_size(input int f3);
    int s;
    s = f3 % 4;
    return (s == 0) ? 1 : (s == 1) ? 2 : 4;
  endfunction

  function automatic bit m_mis(input int f3, input logic [31:0] a);
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input int f3, input logic [31:0] a);
    int v;
    v = ((1 << m_size(f3)) - 1) << (a % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] wd);
    int s;
    s = m_size(f3);
    if (s == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (s == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input logic [31:0] a, input logic [31:0] rd);
    int bits;
    logic [31:0] v, top;
    bits = 8 * m_size(f3);
    v = rd >> (8 * (a % 4));
    if (bits == 32) return v;
    v = v & ((32'd1 << bits) - 32'd1);
    top = v >> (bits - 1);
    if (f3 < 4 && top[0]) v = v - (32'd1 << bits);
    return v;
  endfunction

  // Drive one request; ack after 'waits' ACCESS cycles; report observations
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int waits, input logic [31:0] rd,
                         output int done_cyc, output int req_cyc, output logic stable,
                         output logic we_s, output logic [31:0] addr_s,
                         output logic [31:0] wdata_s, output logic [3:0] be_s,
                         output logic mis_s, output logic berr_s, output logic [31:0] rdata_s);
    done_cyc = -1; req_cyc = 0; stable = 1'b1; we_s = 1'b0; addr_s = '0;
    wdata_s = '0; be_s = '0; mis_s = 1'b0; berr_s = 1'b0; rdata_s = '0;
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    tick();
    start = 1'b0; funct3 = 3'($urandom()); addr = $urandom(); wdata = $urandom();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin
        done_cyc = cyc; mis_s = misaligned; berr_s = bus_err; rdata_s = rdata;
        break;
      end
      if (mem_req) begin
        if (req_cyc == 0) begin
          we_s = mem_we; addr_s = mem_addr; wdata_s = mem_wdata; be_s = mem_be;
        end else if (mem_we !== we_s || mem_addr !== addr_s ||
                     mem_wdata !== wdata_s || mem_be !== be_s) begin
          stable = 1'b0;
        end
        mem_ack   = (req_cyc == waits);
        mem_rdata = mem_ack ? rd : $urandom();
        req_cyc++;
      end
      tick();
      mem_ack = 1'b0;
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h10;
    wdata = 32'hFFFF_FFFF; mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    start = 1'b0; rst = 1'b0;
    tick();
    total++;
    if ({busy, done, misaligned, bus_err, mem_req, mem_we} !== 6'b0 ||
        rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_be !== 4'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b mis=%b berr=%b req=%b we=%b rdata=%h addr=%h wdata=%h be=%b, want all zero",
               busy, done, misaligned, bus_err, mem_req, mem_we, rdata, mem_addr, mem_wdata, mem_be);
    end
  endtask

  task automatic test_directed();
    int dc, rc; logic stb, we, mis, be_err; logic [31:0] ad, wd, rdv; logic [3:0] be;
    // LB, sign-extended top byte
    run_txn(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_1234, dc, rc, stb, we, ad, wd, be, mis, be_err, rdv);
    total++;
    if (ad !== 32'h100 || be !== 4'b1000 || dc !== 2 || rdv !== 32'hFFFF_FF80) begin
      bad++;
      $display("FAIL lb: addr=%h be=%b done_cyc=%0d rdata=%h, want 100 1000 2 ffffff80", ad, be, dc, rdv);
    end
    // LHU, upper half
    run_txn(1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h9ABC_0000, dc, rc, stb, we, ad, wd, be, mis, be_err, rdv);
    total++;
    if (be !== 4'b1100 || rdv !== 32'h0000_9ABC) begin
      bad++;
      $display("FAIL lhu: be=%b rdata=%h, want 1100 00009abc", be, rdv);
    end
    // SB, lane replication, rdata untouched
    run_txn(1'b1, 3'b000, 32'h201, 32'h1234_56A5, 1, 32'hDEAD_BEEF, dc, rc, stb, we, ad, wd, be, mis, be_err, rdv);
    total++;
    if (we !== 1'b1 || be !== 4'b0010 || wd !== 32'hA5A5_A5A5 || rdv !== 32'h0000_9ABC || dc !== 3) begin
      bad++;
      $display("FAIL sb: we=%b be=%b wdata=%h rdata=%h done_cyc=%0d, want 1 0010 a5a5a5a5 00009abc 3",
               we, be, wd, rdv, dc);
    end
    // Misaligned LW aborts without a memory request
    run_txn(1'b0, 3'b010, 32'h6, 32'h0, 0, 32'h0, dc, rc, stb, we, ad, wd, be, mis, be_err, rdv);
    total++;
    if (rc !== 0 || dc !== 1 || mis !== 1'b1 || be_err !== 1'b0) begin
      bad++;
      $display("FAIL lw_misaligned: req_cycles=%0d done_cyc=%0d mis=%b berr=%b, want 0 1 1 0", rc, dc, mis, be_err);
    end
    // Reserved funct3
    run_txn(1'b0, 3'b011, 32'h8, 32'h0, 0, 32'h0, dc, rc, stb, we, ad, wd, be, mis, be_err, rdv);
    total++;
    if (rc !== 0 || dc !== 1 || mis !== 1'b0 || be_err !== 1'b1) begin
      bad++;
      $display("FAIL illegal_f3: req_cycles=%0d done_cyc=%0d mis=%b berr=%b, want 0 1 0 1", rc, dc, mis, be_err);
    end
    exp_rdata = 32'h0000_9ABC;
  endtask

  task automatic test_timeout();
    int dc, rc; logic stb, we, mis, be_err; logic [31:0] ad, wd, rdv; logic [3:0] be;
    run_txn(1'b1, 3'b010, 32'h40, 32'h5555_AAAA, 100, 32'h0, dc, rc, stb, we, ad, wd, be, mis, be_err, rdv);
    total++;
    if (rc !== 4 || dc !== 5 || be_err !== 1'b1 || mem_req !== 1'b0 || rdv !== exp_rdata) begin
      bad++;
      $display("FAIL timeout: req_cycles=%0d done_cyc=%0d berr=%b req=%b rdata=%h, want 4 5 1 0 %h",
               rc, dc, be_err, mem_req, rdv, exp_rdata);
    end
    // Late ack while idle must not do anything
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || rdata !== exp_rdata || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL late_ack: busy=%b done=%b rdata=%h req=%b, want 0 0 %h 0", busy, done, rdata, mem_req, exp_rdata);
    end
  endtask

  task automatic test_busy_ignore();
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40; wdata = 32'h0;
    tick();
    start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h81; wdata = 32'h77;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || mem_be !== 4'b1111) begin
      bad++;
      $display("FAIL busy_ignore: busy=%b addr=%h we=%b be=%b, want 1 00000040 0 1111", busy, mem_addr, mem_we, mem_be);
    end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    exp_rdata = 32'hCAFE_F00D;
    total++;
    if (done !== 1'b1 || rdata !== exp_rdata) begin
      bad++;
      $display("FAIL busy_ignore_done: done=%b rdata=%h, want 1 %h", done, rdata, exp_rdata);
    end
    tick(); tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL no_queue: busy=%b done=%b req=%b, want 0 0 0", busy, done, mem_req);
    end
  endtask

  task automatic test_reset_mid_access();
    int dc, rc; logic stb, we, mis, be_err; logic [31:0] ad, wd, rdv; logic [3:0] be;
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rdata = 32'd0;
    total++;
    if (mem_req !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_access: req=%b done=%b busy=%b, want 0 0 0", mem_req, done, busy);
    end
    // Pending ack arrives after reset
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || rdata !== 32'd0) begin
      bad++;
      $display("FAIL stale_ack: done=%b busy=%b rdata=%h, want 0 0 0", done, busy, rdata);
    end
    run_txn(1'b0, 3'b010, 32'h300, 32'h0, 3, 32'h0BAD_F00D, dc, rc, stb, we, ad, wd, be, mis, be_err, rdv);
    exp_rdata = 32'h0BAD_F00D;
    total++;
    if (dc !== 5 || rc !== 4 || rdv !== exp_rdata || be_err !== 1'b0 || stb !== 1'b1) begin
      bad++;
      $display("FAIL lw_after_reset: done_cyc=%0d req_cycles=%0d rdata=%h berr=%b stable=%b, want 5 4 %h 0 1",
               dc, rc, rdv, be_err, stb, exp_rdata);
    end
  endtask

  task automatic test_random();
    int dc, rc, waits, f3, e_dc, e_rc; logic stb, we, mis, be_err, st, e_mis, e_berr, acc;
    logic [31:0] ad, wd, rdv, a, d, rd; logic [3:0] be;
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = $urandom_range(0, 7);
      a = $urandom();
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      d = $urandom(); rd = $urandom();
      waits = $urandom_range(0, 5);
      run_txn(st, 3'(f3), a, d, waits, rd, dc, rc, stb, we, ad, wd, be, mis, be_err, rdv);
      e_berr = !m_legal(st, f3);
      e_mis  = !e_berr && m_mis(f3, a);
      acc    = !e_berr && !e_mis;
      if (!acc) begin
        e_dc = 1; e_rc = 0;
      end else if (waits < int'(TMO)) begin
        e_dc = waits + 2; e_rc = waits + 1;
        if (!st) exp_rdata = m_load(f3, a, rd);
      end else begin
        e_dc = int'(TMO) + 1; e_rc = int'(TMO); e_berr = 1'b1;
      end
      total++;
      if (dc !== e_dc || rc !== e_rc || mis !== e_mis || be_err !== e_berr || rdv !== exp_rdata) begin
        bad++;
        $display("FAIL rand_status[%0d]: done_cyc=%0d req_cycles=%0d mis=%b berr=%b rdata=%h, want %0d %0d %b %b %h",
                 n, dc, rc, mis, be_err, rdv, e_dc, e_rc, e_mis, e_berr, exp_rdata);
      end
      if (acc) begin
        total++;
        if (ad !== {a[31:2], 2'b00} || be !== m_be(f3, a) || we !== st || stb !== 1'b1 ||
            (st && wd !== m_wdata(f3, d))) begin
          bad++;
          $display("FAIL rand_bus[%0d]: addr=%h be=%b we=%b wdata=%h stable=%b, want %h %b %b %h 1",
                   n, ad, be, we, wd, stb, {a[31:2], 2'b00}, m_be(f3, a), st, m_wdata(f3, d));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0;
    wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_directed();
    test_timeout();
    test_busy_ignore();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: the number of ACCESS cycles without mem_ack before the access is aborted.
REQ-002 clk  in  1  the single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 start  in  1  single-cycle request strobe from the execute stage.
REQ-005 is_store  in  1  1 = store, 0 = load; sampled with start.
REQ-006 funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; sampled with start.
REQ-007 addr  in  32  effective address, taken from the ALU result alu_out; sampled with start.
REQ-008 wdata  in  32  store data (rs2); sampled with start.
REQ-009 busy  out  1  high in every non-IDLE state.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 rdata  out  32  aligned and extended load result.
REQ-012 misaligned  out  1  access aborted for misalignment; valid with done.
REQ-013 bus_err  out  1  access aborted for illegal funct3 or timeout; valid with done.
REQ-014 mem_req  out  1  memory request, held until acknowledged.
REQ-015 mem_we  out  1  write enable.
REQ-016 mem_addr  out  32  word address; bits [1:0] SHALL always be 00.
REQ-017 mem_wdata  out  32  lane-replicated store data.
REQ-018 mem_be  out  4  byte enables.
REQ-019 mem_ack  in  1  memory acknowledge; one cycle.
REQ-020 mem_rdata  in  32  read word; valid with mem_ack.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-022 From IDLE, start SHALL move the FSM to ACCESS when the request is legal and aligned, and otherwise to RESP.
REQ-023 In ACCESS, mem_ack SHALL move the FSM to RESP; a timeout SHALL also move it to RESP. RESP SHALL always return to IDLE.
REQ-024 start while busy=1 SHALL be ignored, with no queuing.
REQ-025 Alignment: H/HU with addr[0]=1, or W with addr[1:0]≠00, SHALL set misaligned=1 and SHALL issue no mem_req.
REQ-026 Illegal funct3: 011/110/111, or is_store with funct3[2]=1, SHALL set bus_err=1 and SHALL issue no mem_req.
REQ-027 mem_req SHALL be 1 in every ACCESS cycle, with mem_addr, mem_we, mem_be and mem_wdata held stable.
REQ-028 Byte enables: B = 0001<<addr[1:0]; H = 0011 when addr[1]=0, else 1100; W = 1111. These SHALL apply to loads and stores alike.
REQ-029 Store data: SB SHALL replicate wdata[7:0] into all 4 lanes; SH SHALL replicate wdata[15:0] into both halves; SW SHALL pass wdata through.
REQ-030 Load data: the lane selected by addr[1:0] SHALL be captured on mem_ack, then sign-extended (B/H) or zero-extended (BU/HU). Stores SHALL leave rdata unchanged.
REQ-031 Latency: start at cycle 0 SHALL give ACCESS at cycle 1; mem_ack at cycle k≥1 SHALL give done at cycle k+1. With zero wait states, done SHALL occur at cycle 2. An aborted request SHALL give done at cycle 1.
REQ-032 A wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without mem_ack.
REQ-033 When the wait counter reaches TIMEOUT_CYCLES, the FSM SHALL go to RESP with bus_err=1, drop mem_req and leave rdata unchanged.
REQ-034 If mem_ack and the timeout occur in the same cycle, mem_ack SHALL win.
REQ-035 misaligned and bus_err SHALL be set only on done and cleared on the next accepted start; rdata SHALL hold until the next load completion.
REQ-036 mem_ack received outside ACCESS SHALL be ignored.

Reset
REQ-037 When rst=1, the block SHALL enter IDLE at the next edge, and all outputs and the counter SHALL go to 0 (rdata=0, mem_be=0000).
REQ-038 A reset in ACCESS SHALL drop mem_req at the next edge, SHALL NOT pulse done, and SHALL cause the pending mem_ack to be discarded.
REQ-039 A start asserted together with rst SHALL be ignored.

Structure
REQ-040 The funct3 load/store encodings and the FSM state enum SHALL reside in the shared package rv32i_pkg.
REQ-041 The combinational lane-select and extend logic SHALL be the sub-module load_align (inputs mem_rdata, addr[1:0], funct3; output 32-bit result).

Verification
REQ-042 LB, addr=0x103, mem_rdata=0x80FF_1234, ack at cycle 1 -> mem_addr=0x100, mem_be=1000, done at cycle 2, rdata=0xFFFF_FF80.
REQ-043 LHU, addr=0x102, mem_rdata=0x9ABC_0000 -> mem_be=1100, rdata=0x0000_9ABC.
REQ-044 SB, addr=0x201, wdata=0x1234_56A5 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5_A5A5, rdata unchanged.
REQ-045 LW, addr=0x6 -> no mem_req, done at cycle 1, misaligned=1; then start with funct3=011 -> done, bus_err=1.
REQ-046 SW, no ack, TIMEOUT_CYCLES=4 -> mem_req high 4 cycles then low, done with bus_err=1; a late ack SHALL be ignored.
REQ-047 LW with 3 wait states, rst asserted at cycle 2 -> mem_req low at cycle 3, no done, IDLE; a following LW SHALL complete normally.
